// File: rtl/spi_msg_ctrl.sv
// spi_msg_ctrl: frames SPI select windows into command + payload messages
// for the register block and sequences the reply bytes back to the front-end.
module spi_msg_ctrl #(
    parameter int unsigned DATA_BYTES = 8,
    parameter logic [7:0]  TX_FILL    = 8'h00
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      spi_ssel,
    input  logic [7:0]                rx_byte,
    input  logic                      rx_byte_valid,
    input  logic                      tx_byte_req,
    output logic [7:0]                tx_byte,
    output logic [7:0]                spi_cmd,
    output logic [8*DATA_BYTES-1:0]   spi_rxdata,
    output logic                      spi_msg_end,
    input  logic [8*DATA_BYTES-1:0]   spi_txdata,
    input  logic                      spi_txdata_valid,
    output logic [3:0]                msg_len,
    output logic                      msg_ovf
);

    localparam int unsigned    W        = 8 * DATA_BYTES;
    localparam logic [3:0]     MAX_LEN  = 4'(DATA_BYTES);
    localparam logic [W-1:0]   FILL_ALL = {DATA_BYTES{TX_FILL}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_TXLD,
        ST_DATA,
        ST_END
    } state_t;

    state_t       state_q, state_d;
    logic [7:0]   cmd_q, cmd_d;
    logic [W-1:0] rxdata_q, rxdata_d;
    logic [W-1:0] txbuf_q, txbuf_d;
    logic [7:0]   tx_byte_q, tx_byte_d;
    logic [3:0]   msg_len_q, msg_len_d;
    logic         msg_ovf_q, msg_ovf_d;
    logic         rx_take;
    logic [W-1:0] tx_src;

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            rxdata_q  <= '0;
            txbuf_q   <= FILL_ALL;
            tx_byte_q <= TX_FILL;
            msg_len_q <= '0;
            msg_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            rxdata_q  <= rxdata_d;
            txbuf_q   <= txbuf_d;
            tx_byte_q <= tx_byte_d;
            msg_len_q <= msg_len_d;
            msg_ovf_q <= msg_ovf_d;
        end
    end

    // Next-state, message capture and reply byte sequencing
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        rxdata_d  = rxdata_q;
        txbuf_d   = txbuf_q;
        tx_byte_d = tx_byte_q;
        msg_len_d = msg_len_q;
        msg_ovf_d = msg_ovf_q;
        rx_take   = 1'b0;
        tx_src    = spi_txdata_valid ? spi_txdata : FILL_ALL;

        case (state_q)
            ST_IDLE: begin
                if (spi_ssel) begin
                    state_d   = ST_CMD;
                    rxdata_d  = '0;
                    msg_len_d = '0;
                    msg_ovf_d = 1'b0;
                    tx_byte_d = TX_FILL;
                end
            end
            ST_CMD: begin
                if (!spi_ssel) begin
                    state_d = ST_IDLE;
                end else if (rx_byte_valid) begin
                    cmd_d   = rx_byte;
                    state_d = ST_TXLD;
                end
            end
            ST_TXLD: begin
                if (!spi_ssel) begin
                    state_d = ST_END;
                end else begin
                    // The reply buffer is kept pre-shifted: tx_byte holds the
                    // current byte and txbuf holds the rest, so a request during
                    // this cycle still yields byte 0.
                    tx_byte_d = tx_src[W-1 -: 8];
                    txbuf_d   = {tx_src[W-9:0], TX_FILL};
                    rx_take   = rx_byte_valid;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!spi_ssel) begin
                    state_d = ST_END;
                end else begin
                    rx_take = rx_byte_valid;
                    if (tx_byte_req) begin
                        tx_byte_d = txbuf_q[W-1 -: 8];
                        txbuf_d   = {txbuf_q[W-9:0], TX_FILL};
                    end
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rx_take) begin
            if (msg_len_q < MAX_LEN) begin
                for (int unsigned i = 0; i < DATA_BYTES; i++) begin
                    if (msg_len_q == 4'(i)) begin
                        rxdata_d[W-1-8*i -: 8] = rx_byte;
                    end
                end
                msg_len_d = msg_len_q + 4'd1;
            end else begin
                msg_ovf_d = 1'b1;
            end
        end
    end

    assign tx_byte     = tx_byte_q;
    assign spi_cmd     = cmd_q;
    assign spi_rxdata  = rxdata_q;
    assign spi_msg_end = (state_q == ST_END);
    assign msg_len     = msg_len_q;
    assign msg_ovf     = msg_ovf_q;

endmodule

// File: tb/tb_spi_msg_ctrl.sv
// Self-checking bench for spi_msg_ctrl: table of whole messages plus
// directed sequences for reply bytes, early deselects and reset.
module tb_spi_msg_ctrl;

    logic        clk;
    logic        reset_n;
    logic        spi_ssel;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic        tx_byte_req;
    logic [7:0]  tx_byte;
    logic [7:0]  spi_cmd;
    logic [63:0] spi_rxdata;
    logic        spi_msg_end;
    logic [63:0] spi_txdata;
    logic        spi_txdata_valid;
    logic [3:0]  msg_len;
    logic        msg_ovf;

    int tests;
    int failed;
    int pulse_cnt;

    spi_msg_ctrl #(
        .DATA_BYTES(8),
        .TX_FILL   (8'h00)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .spi_ssel        (spi_ssel),
        .rx_byte         (rx_byte),
        .rx_byte_valid   (rx_byte_valid),
        .tx_byte_req     (tx_byte_req),
        .tx_byte         (tx_byte),
        .spi_cmd         (spi_cmd),
        .spi_rxdata      (spi_rxdata),
        .spi_msg_end     (spi_msg_end),
        .spi_txdata      (spi_txdata),
        .spi_txdata_valid(spi_txdata_valid),
        .msg_len         (msg_len),
        .msg_ovf         (msg_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count message-end pulses seen at clock edges
    always @(posedge clk) begin
        if (spi_msg_end) pulse_cnt <= pulse_cnt + 1;
    end

    typedef struct {
        logic [7:0]  cmd;
        int          n;
        logic [79:0] dat;
        logic [63:0] exp_rx;
        logic [3:0]  exp_len;
        logic        exp_ovf;
    } msg_vec_t;

    msg_vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_byte_valid = 1'b1;
        rx_byte       = b;
        tick();
        rx_byte_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd"},  64'(spi_cmd), 64'h0);
        check({tag, "_rx"},   spi_rxdata, 64'h0);
        check({tag, "_end"},  64'(spi_msg_end), 64'h0);
        check({tag, "_tx"},   64'(tx_byte), 64'h0);
        check({tag, "_len"},  64'(msg_len), 64'h0);
        check({tag, "_ovf"},  64'(msg_ovf), 64'h0);
    endtask

    initial begin
        logic [79:0] d;
        logic [71:0] exp_tx;
        int          p0;

        tests            = 0;
        failed           = 0;
        pulse_cnt        = 0;
        reset_n          = 1'b0;
        spi_ssel         = 1'b0;
        rx_byte          = 8'h00;
        rx_byte_valid    = 1'b0;
        tx_byte_req      = 1'b0;
        spi_txdata       = 64'h0;
        spi_txdata_valid = 1'b0;

        vecs[0] = '{8'h10, 8, 80'h01020304050607080000, 64'h0102030405060708, 4'd8, 1'b0};
        vecs[1] = '{8'h11, 2, 80'hAA550000000000000000, 64'hAA55000000000000, 4'd2, 1'b0};
        vecs[2] = '{8'h12, 1, 80'h7E000000000000000000, 64'h7E00000000000000, 4'd1, 1'b0};
        vecs[3] = '{8'h10, 9, 80'h01020304050607080900, 64'h0102030405060708, 4'd8, 1'b1};
        vecs[4] = '{8'h20, 0, 80'h0,                     64'h0,                4'd0, 1'b0};

        tick();
        tick();
        check_reset_vals("reset");
        reset_n = 1'b1;
        tick();

        // Whole messages from the table
        for (int v = 0; v < 5; v++) begin
            p0       = pulse_cnt;
            spi_ssel = 1'b1;
            tick();
            send_rx(vecs[v].cmd);
            tick();
            d = vecs[v].dat;
            for (int b = 0; b < vecs[v].n; b++) begin
                send_rx(d[79:72]);
                d = d << 8;
                tick();
            end
            spi_ssel = 1'b0;
            tick();
            check($sformatf("v%0d_end_latency", v), 64'(spi_msg_end), 64'h1);
            tick();
            check($sformatf("v%0d_end_width", v), 64'(spi_msg_end), 64'h0);
            check($sformatf("v%0d_pulses", v), 64'(pulse_cnt - p0), 64'h1);
            check($sformatf("v%0d_cmd", v), 64'(spi_cmd), 64'(vecs[v].cmd));
            check($sformatf("v%0d_rxdata", v), spi_rxdata, vecs[v].exp_rx);
            check($sformatf("v%0d_len", v), 64'(msg_len), 64'(vecs[v].exp_len));
            check($sformatf("v%0d_ovf", v), 64'(msg_ovf), 64'(vecs[v].exp_ovf));
        end

        // Empty select window: no pulse, command held
        p0       = pulse_cnt;
        spi_ssel = 1'b1;
        tick();
        tick();
        spi_ssel = 1'b0;
        tick();
        tick();
        tick();
        check("empty_pulses", 64'(pulse_cnt - p0), 64'h0);
        check("empty_cmd", 64'(spi_cmd), 64'h20);

        // Reply bytes with valid tx data
        spi_txdata       = 64'hDEADBEEF01234567;
        spi_txdata_valid = 1'b1;
        spi_ssel         = 1'b1;
        tick();
        check("tx_fill_in_cmd", 64'(tx_byte), 64'h00);
        send_rx(8'h30);
        tick();
        check("tx_byte0", 64'(tx_byte), 64'hDE);
        exp_tx = 72'hADBEEF012345670000;
        for (int r = 0; r < 9; r++) begin
            tx_byte_req = 1'b1;
            tick();
            tx_byte_req = 1'b0;
            check($sformatf("tx_req%0d", r + 1), 64'(tx_byte), 64'(exp_tx[71:64]));
            exp_tx = exp_tx << 8;
        end
        spi_ssel = 1'b0;
        tick();
        tick();

        // Reply bytes with invalid tx data: fill only
        spi_txdata_valid = 1'b0;
        spi_ssel         = 1'b1;
        tick();
        send_rx(8'h31);
        tick();
        check("txinv_byte0", 64'(tx_byte), 64'h00);
        for (int r = 0; r < 3; r++) begin
            tx_byte_req = 1'b1;
            tick();
            tx_byte_req = 1'b0;
            check($sformatf("txinv_req%0d", r + 1), 64'(tx_byte), 64'h00);
        end
        spi_ssel = 1'b0;
        tick();
        tick();

        // rx byte and tx request in the reply-latch cycle
        spi_txdata_valid = 1'b1;
        spi_ssel         = 1'b1;
        tick();
        send_rx(8'h40);
        rx_byte_valid = 1'b1;
        rx_byte       = 8'h5A;
        tx_byte_req   = 1'b1;
        tick();
        rx_byte_valid = 1'b0;
        tx_byte_req   = 1'b0;
        check("txld_tx_byte0", 64'(tx_byte), 64'hDE);
        tx_byte_req = 1'b1;
        tick();
        tx_byte_req = 1'b0;
        check("txld_tx_byte1", 64'(tx_byte), 64'hAD);
        spi_ssel = 1'b0;
        tick();
        tick();
        check("txld_rxdata", spi_rxdata, 64'h5A00000000000000);
        check("txld_len", 64'(msg_len), 64'h1);

        // Deselect while latching the reply: command-only message still ends
        p0       = pulse_cnt;
        spi_ssel = 1'b1;
        tick();
        send_rx(8'h50);
        spi_ssel = 1'b0;
        tick();
        check("txld_drop_end", 64'(spi_msg_end), 64'h1);
        tick();
        check("txld_drop_pulses", 64'(pulse_cnt - p0), 64'h1);
        check("txld_drop_cmd", 64'(spi_cmd), 64'h50);

        // Reset mid-payload aborts the message
        spi_ssel = 1'b1;
        tick();
        send_rx(8'h60);
        tick();
        send_rx(8'h11);
        send_rx(8'h22);
        send_rx(8'h33);
        reset_n = 1'b0;
        tick();
        check_reset_vals("midrst");
        p0      = pulse_cnt;
        reset_n = 1'b1;
        tick();
        tick();
        spi_ssel = 1'b0;
        tick();
        tick();
        tick();
        check("midrst_no_pulse", 64'(pulse_cnt - p0), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
